// File: rtl/usb_slavefifo_rx_stream_if.sv
// FX3 slave-FIFO reader output stream.
// Valid/ready word stream towards the consumer.
interface usb_slavefifo_rx_stream_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/usb_slavefifo_rx_stream.sv
// FX3 slave-FIFO stream-out reader.
// Tracks read latency so backpressure never loses words.
module usb_slavefifo_rx_stream #(
  parameter int         DATA_W     = 32,
  parameter int         RD_LATENCY = 2,
  parameter int         BUF_DEPTH  = 8,
  parameter int         WM_TAIL    = 0,
  parameter logic [1:0] FIFO_ADDR  = 2'b11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flag_rdy,
  input  logic              flag_wm,
  input  logic [DATA_W-1:0] usb_data,
  output logic              slcs_n,
  output logic              slwr_n,
  output logic              pktend_n,
  output logic [1:0]        fifo_addr,
  output logic              slrd_n,
  output logic              sloe_n,
  usb_slavefifo_rx_stream_if.master m,
  output logic [31:0]       rx_words,
  output logic              err_ovf,
  output logic              busy
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int SW = AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    TAIL,
    DRAIN
  } state_t;

  state_t                  state;
  logic [3:0]              tail;
  logic [RD_LATENCY-1:0]   pipe;
  logic [DATA_W-1:0]       mem [BUF_DEPTH];
  logic [AW-1:0]           wp;
  logic [AW-1:0]           rp;
  logic [SW-1:0]           count;
  logic [SW-1:0]           inflight;
  logic                    space;
  logic                    issue;
  logic                    push;
  logic                    pop;
  logic                    full;

  assign slcs_n    = 1'b0;
  assign slwr_n    = 1'b1;
  assign pktend_n  = 1'b1;
  assign fifo_addr = FIFO_ADDR;

  assign busy      = (state != IDLE);
  assign push      = pipe[RD_LATENCY-1];
  assign full      = (count == SW'(BUF_DEPTH));
  assign m.m_valid = (count != '0);
  assign m.m_data  = mem[rp];
  assign pop       = m.m_valid & m.m_ready;
  assign space     = (count + inflight) < SW'(BUF_DEPTH);

  // Words requested but not yet landed on the bus.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++)
      inflight = inflight + SW'(pipe[i]);
  end

  // Read request only while a landing slot is guaranteed.
  always_comb begin
    issue = 1'b0;
    unique case (state)
      READ:    issue = en & flag_wm & space;
      TAIL:    issue = en & space & (tail != '0);
      default: issue = 1'b0;
    endcase
  end

  // Burst control FSM with registered strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      tail   <= '0;
      slrd_n <= 1'b1;
      sloe_n <= 1'b1;
    end else begin
      slrd_n <= ~issue;
      unique case (state)
        IDLE: begin
          if (en && flag_rdy && flag_wm) begin
            state  <= READ;
            sloe_n <= 1'b0;
          end
        end
        READ: begin
          if (!en) begin
            state <= DRAIN;
          end else if (!flag_wm) begin
            if (WM_TAIL == 0) begin
              state <= DRAIN;
            end else begin
              state <= TAIL;
              tail  <= 4'(WM_TAIL);
            end
          end
        end
        TAIL: begin
          if (!en || tail == '0) begin
            state <= DRAIN;
          end else if (issue) begin
            tail <= tail - 1'b1;
            if (tail == 4'd1)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight == '0) begin
            state  <= IDLE;
            sloe_n <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          sloe_n <= 1'b1;
        end
      endcase
    end
  end

  // Issue bits ride alongside the FX3 read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  // FWFT buffer absorbing in-flight words under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      rx_words <= '0;
      err_ovf  <= 1'b0;
    end else begin
      if (push && !full) begin
        mem[wp] <= usb_data;
        wp      <= wp + 1'b1;
      end
      if (push && full)
        err_ovf <= 1'b1;
      if (pop) begin
        rp       <= rp + 1'b1;
        rx_words <= rx_words + 1'b1;
      end
      unique case ({push && !full, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_slavefifo_rx_stream.sv
// Directed bench for the FX3 slave-FIFO reader.
// Two instances: 32b/lat2/tail4 and 16b/lat3/tail0.
module tb_usb_slavefifo_rx_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        en_a, rdy_a, wm_a;
  logic [31:0] d_a;
  logic        cs_a, wr_a, pe_a, rd_a, oe_a;
  logic        ovf_a, busy_a;
  logic [1:0]  fa_a;
  logic [31:0] rxw_a;

  logic        en_b, rdy_b, wm_b;
  logic [15:0] d_b;
  logic        cs_b, wr_b, pe_b, rd_b, oe_b;
  logic        ovf_b, busy_b;
  logic [1:0]  fa_b;
  logic [31:0] rxw_b;

  usb_slavefifo_rx_stream_if #(.DATA_W(32)) sa ();
  usb_slavefifo_rx_stream_if #(.DATA_W(16)) sb ();

  usb_slavefifo_rx_stream #(
    .DATA_W(32), .RD_LATENCY(2), .BUF_DEPTH(8),
    .WM_TAIL(4), .FIFO_ADDR(2'b11)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a),
    .flag_rdy(rdy_a), .flag_wm(wm_a),
    .usb_data(d_a), .slcs_n(cs_a), .slwr_n(wr_a),
    .pktend_n(pe_a), .fifo_addr(fa_a),
    .slrd_n(rd_a), .sloe_n(oe_a), .m(sa.master),
    .rx_words(rxw_a), .err_ovf(ovf_a), .busy(busy_a)
  );

  usb_slavefifo_rx_stream #(
    .DATA_W(16), .RD_LATENCY(3), .BUF_DEPTH(8),
    .WM_TAIL(0), .FIFO_ADDR(2'b01)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
    .flag_rdy(rdy_b), .flag_wm(wm_b),
    .usb_data(d_b), .slcs_n(cs_b), .slwr_n(wr_b),
    .pktend_n(pe_b), .fifo_addr(fa_b),
    .slrd_n(rd_b), .sloe_n(oe_b), .m(sb.master),
    .rx_words(rxw_b), .err_ovf(ovf_b), .busy(busy_b)
  );

  // FX3 models: a strobe low in cycle c puts the next
  // word on the bus in cycle c+RD_LATENCY-1.
  logic [3:0]  hist_a = '0;
  logic [31:0] next_a = 32'h1000;
  int          iss_a  = 0;
  always @(negedge clk) begin
    hist_a = {hist_a[2:0], ~rd_a};
    if (rd_a === 1'b0) iss_a++;
    if (hist_a[1] === 1'b1) begin
      d_a = next_a;
      next_a++;
    end else begin
      d_a = 32'hDEAD_BEEF;
    end
  end

  logic [3:0]  hist_b = '0;
  logic [15:0] next_b = 16'h1000;
  int          iss_b  = 0;
  always @(negedge clk) begin
    hist_b = {hist_b[2:0], ~rd_b};
    if (rd_b === 1'b0) iss_b++;
    if (hist_b[2] === 1'b1) begin
      d_b = next_b;
      next_b++;
    end else begin
      d_b = 16'hBEEF;
    end
  end

  logic [31:0] exp_a = 32'h1000;
  logic [15:0] exp_b = 16'h1000;
  logic [31:0] last_a = '0;
  int          snap;
  int          base;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // One cycle; handshakes are scored at the negedge.
  task automatic tick();
    @(negedge clk);
    if (sa.m_valid === 1'b1 && sa.m_ready === 1'b1) begin
      chk("a_data", 64'(sa.m_data), 64'(exp_a));
      last_a = sa.m_data;
      exp_a++;
    end
    if (sb.m_valid === 1'b1 && sb.m_ready === 1'b1) begin
      chk("b_data", 64'(sb.m_data), 64'(exp_b));
      exp_b++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en_a = 0; rdy_a = 0; wm_a = 0; sa.m_ready = 0;
    en_b = 0; rdy_b = 0; wm_b = 0; sb.m_ready = 0;
    repeat (5) tick();
    rst_n = 1'b1;

    chk("a_const", {cs_a, wr_a, pe_a, fa_a}, 5'b01111);
    chk("b_const", {cs_b, wr_b, pe_b, fa_b}, 5'b01101);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("a_idle", {rd_a, oe_a, sa.m_valid, busy_a}, 4'b1100);
      chk("b_idle", {rd_b, oe_b, sb.m_valid, busy_b}, 4'b1100);
    end
    chk("a_rst_rxw", rxw_a, 0);
    chk("b_rst_rxw", rxw_b, 0);
    chk("rst_ovf", {ovf_a, ovf_b}, 2'b00);

    // Streaming burst, watermark high 40 cycles
    sa.m_ready = 1; en_a = 1; rdy_a = 1; wm_a = 1;
    base = iss_a;
    repeat (3) tick();
    chk("a_lat_lo", sa.m_valid, 1'b0);
    tick();
    chk("a_lat_hi", sa.m_valid, 1'b1);
    chk("a_oe", oe_a, 1'b0);
    repeat (16) tick();
    rdy_a = 0;
    repeat (20) tick();
    chk("a_rdy_drop", rd_a, 1'b0);
    wm_a = 0;
    tick();
    snap = iss_a;
    chk("a_burst_n", snap - base, 39);
    for (int i = 0; i < 50 && busy_a; i++) tick();
    chk("a_idle_end", busy_a, 1'b0);
    chk("a_tail", iss_a - snap, 4);
    chk("a_last", last_a, 32'h102A);
    chk("a_rxw", rxw_a, 43);
    chk("a_drained", sa.m_valid, 1'b0);
    chk("a_oe_off", oe_a, 1'b1);

    // Backpressure fills the buffer exactly
    sa.m_ready = 0; rdy_a = 1; wm_a = 1;
    base = iss_a;
    repeat (20) tick();
    chk("bp_rd", rd_a, 1'b1);
    chk("bp_cnt", iss_a - base, 8);
    chk("bp_ovf", ovf_a, 1'b0);
    chk("bp_valid", sa.m_valid, 1'b1);
    chk("bp_head", sa.m_data, 32'h102B);
    sa.m_ready = 1;
    repeat (10) tick();
    wm_a = 0;
    for (int i = 0; i < 50 && busy_a; i++) tick();
    repeat (3) tick();
    chk("bp_idle", busy_a, 1'b0);
    chk("bp_rxw", rxw_a, iss_a);
    chk("bp_ovf2", ovf_a, 1'b0);
    en_a = 0;

    // Random backpressure on the 16-bit lat-3 reader
    en_b = 1; rdy_b = 1; wm_b = 1;
    for (int i = 0; i < 20000 && iss_b < 1000; i++) begin
      sb.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    wm_b = 0;
    for (int i = 0; i < 200 && busy_b; i++) begin
      sb.m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    sb.m_ready = 1;
    repeat (12) tick();
    chk("b_idle_end", busy_b, 1'b0);
    chk("b_cnt", (iss_b >= 1000 && iss_b <= 1001), 1'b1);
    chk("b_rxw", rxw_b, iss_b);
    chk("b_ovf", ovf_b, 1'b0);
    chk("b_empty", sb.m_valid, 1'b0);

    // Reset with two reads in flight
    sa.m_ready = 1; en_a = 1; rdy_a = 1; wm_a = 1;
    repeat (3) tick();
    chk("r_pre", rd_a, 1'b0);
    rst_n = 0; en_a = 0; wm_a = 0;
    tick();
    rst_n = 1;
    chk("r_outs", {rd_a, oe_a, sa.m_valid, busy_a, ovf_a},
        5'b11000);
    chk("r_rxw", rxw_a, 0);
    repeat (10) tick();
    chk("r_quiet", {sa.m_valid, busy_a}, 2'b00);
    chk("r_rxw2", rxw_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_slavefifo_rx_stream.md
Name: usb_slavefifo_rx_stream

Overview:
- Parametrised FX3 slave-FIFO stream-out reader: pulls words from the FX3 over the synchronous slave-FIFO bus and delivers them on a valid/ready stream.
- Accounts for the FX3 read latency with an in-flight tracker and a local buffer, so downstream backpressure never drops data.
- Continues reading for a configurable tail after the watermark flag drops.
- Sits between the FX3 pins and the video/packet consumer in the USB domain.

Parameters:
- DATA_W, 32: slave-FIFO and stream data width (16 or 32).
- RD_LATENCY, 2: cycles from slrd_n=0 sample to valid usb_data (1..4).
- BUF_DEPTH, 8: local buffer depth in words; power of 2, must be >= RD_LATENCY+2.
- WM_TAIL, 0: extra reads issued after flag_wm falls (matches the FX3 watermark setting, 0..15).
- FIFO_ADDR, 2'b11: socket address driven on fifo_addr.

Ports:
- clk  in  1  FX3 PCLK domain clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  reading enable; level.
- flag_rdy  in  1  high = thread holds data (DMA ready).
- flag_wm  in  1  high = more than watermark words remain.
- usb_data  in  DATA_W  FX3 data bus.
- slcs_n  out  1  constant 0.
- slwr_n  out  1  constant 1.
- pktend_n  out  1  constant 1.
- fifo_addr  out  2  constant FIFO_ADDR.
- slrd_n  out  1  read strobe, registered.
- sloe_n  out  1  output enable, registered.
- m_data  out  DATA_W  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- rx_words  out  32  count of words delivered (m_valid&m_ready); wraps at 2^32.
- err_ovf  out  1  sticky: capture attempted with buffer full.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, slrd_n=1, sloe_n=1, m_valid=0, buffer and in-flight pipe cleared, rx_words=0, err_ovf=0, tail counter=0. Reset mid-burst discards in-flight words.
- States:
  - IDLE: if en & flag_rdy & flag_wm, go to READ.
  - READ: each cycle, issue a read (slrd_n=0 next cycle) iff count+inflight < BUF_DEPTH. On flag_wm=0, load tail=WM_TAIL and go to TAIL (if WM_TAIL=0, go straight to DRAIN). On en=0, go to DRAIN.
  - TAIL: issue reads under the same space rule. Tail decrements per issued read; at 0 go to DRAIN. en=0 also goes to DRAIN.
  - DRAIN: no reads. When inflight=0, go to IDLE.
- sloe_n=0 in READ, TAIL and DRAIN; 1 in IDLE.
- In-flight tracking: RD_LATENCY-deep shift of issue bits, aligned to the registered slrd_n. usb_data is captured into the buffer when the shift tail is 1. inflight = popcount of the pipe.
- Buffer: FWFT; m_valid = count!=0; pop on m_valid&m_ready. Push and pop may occur in the same cycle; count is unchanged.
- Capture with count==BUF_DEPTH (not reachable with legal parameters): word dropped, err_ovf set.
- Data order is preserved exactly; no duplication, no loss while m_ready toggles.
- flag_rdy falling during READ has no effect; only flag_wm and en end a burst.
- Latency: first m_valid appears RD_LATENCY+2 cycles after the IDLE->READ decision cycle.

Test Plan:
- Reset 5 cycles, release, flags low -> slrd_n=1, sloe_n=1, m_valid=0, rx_words=0, busy=0 for 20 cycles.
- RD_LATENCY=2, BUF_DEPTH=8, m_ready=1, incrementing model data 0x1000.., flag_wm high 40 cycles -> m_data sequence 0x1000.. contiguous, no gaps; rx_words equals number of issued reads.
- WM_TAIL=4: flag_wm falls at cycle N -> exactly 4 further slrd_n=0 cycles, then DRAIN; last delivered word = 4 words past the watermark word; busy drops after inflight=0.
- m_ready held 0 during a burst -> slrd_n rises once count+inflight=8; exactly 8 words buffered; err_ovf stays 0; releasing m_ready resumes in order.
- Random m_ready (50%), 1000 words, RD_LATENCY=3, DATA_W=16 -> scoreboard match, rx_words=1000, err_ovf=0.
- rst_n pulsed low mid-burst with 2 words in flight -> those words are not delivered; outputs at reset values the next cycle.
